// File: rtl/goertzel_core.sv
// Single-bin Goertzel filter: runs the second-order recursion over a block of
// samples, then squares/cross-multiplies the final state into a bin power.
module goertzel_core #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [COEF_W-1:0]         coef,
  input  logic [LEN_W-1:0]          block_len,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DATA_W-1:0]  s_data,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [2*ACC_W-1:0]        r_power,
  output logic                      busy,
  output logic                      overflow
);

  // coef is Q2.16, so (coef*s1)>>>16 lands exactly in ACC_W+2 bits
  localparam int PW  = COEF_W + ACC_W;
  localparam int TW  = ACC_W + 2;
  localparam int AW2 = 2 * ACC_W + 2;

  typedef enum logic [2:0] {IDLE, ACCUM, SQ1, SQ2, CROSS, DONE} state_e;

  state_e                    state_q, state_d;
  logic signed [COEF_W-1:0]  coef_q, coef_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   s1_q, s1_d;
  logic signed [ACC_W-1:0]   s2_q, s2_d;
  logic signed [AW2-1:0]     acc_q, acc_d;
  logic [2*ACC_W-1:0]        pow_q, pow_d;
  logic                      ovf_q, ovf_d;

  // Recursion datapath
  logic signed [PW-1:0]      prod;
  logic signed [TW-1:0]      p, x_ext, s2_ext, t;
  logic                      t_ovf;
  logic signed [ACC_W-1:0]   t_sat;
  logic [LEN_W-1:0]          cnt_inc;
  logic                      unused_prod_lo;

  assign prod           = coef_q * s1_q;
  assign p              = prod[PW-1:16];
  assign unused_prod_lo = ^prod[15:0];
  assign x_ext          = {{(TW-DATA_W){s_data[DATA_W-1]}}, s_data};
  assign s2_ext         = {{2{s2_q[ACC_W-1]}}, s2_q};
  assign t              = x_ext + p - s2_ext;
  // t fits ACC_W signed only when its top three bits agree
  assign t_ovf          = !((&t[TW-1:ACC_W-1]) || !(|t[TW-1:ACC_W-1]));
  assign t_sat          = !t_ovf ? t[ACC_W-1:0]
                        : t[TW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
  assign cnt_inc        = cnt_q + LEN_W'(1);

  // Power datapath: one shared multiplier for s1^2, s2^2 and p*s2
  logic signed [TW-1:0]      m_a;
  logic signed [ACC_W-1:0]   m_b;
  logic signed [AW2-1:0]     ma_x, mb_x, mul, acc_x;

  // Select multiplier operands by phase
  always_comb begin
    m_a = p;
    m_b = s2_q;
    case (state_q)
      SQ1: begin m_a = {{2{s1_q[ACC_W-1]}}, s1_q}; m_b = s1_q; end
      SQ2: begin m_a = s2_ext;                    m_b = s2_q; end
      default: ;
    endcase
  end

  assign ma_x  = {{(AW2-TW){m_a[TW-1]}}, m_a};
  assign mb_x  = {{(AW2-ACC_W){m_b[ACC_W-1]}}, m_b};
  assign mul   = ma_x * mb_x;
  assign acc_x = acc_q - mul;

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      coef_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      acc_q   <= '0;
      pow_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      acc_q   <= acc_d;
      pow_q   <= pow_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath updates per phase
  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    acc_d   = acc_q;
    pow_d   = pow_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start && block_len != '0) begin
          coef_d  = coef;
          len_d   = block_len;
          cnt_d   = '0;
          s1_d    = '0;
          s2_d    = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (s_valid) begin
          s2_d  = s1_q;
          s1_d  = t_sat;
          ovf_d = ovf_q | t_ovf;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = SQ1;
        end
      end
      SQ1: begin
        acc_d   = mul;
        state_d = SQ2;
      end
      SQ2: begin
        acc_d   = acc_q + mul;
        state_d = CROSS;
      end
      CROSS: begin
        acc_d = acc_x;
        if (acc_x[AW2-1])                pow_d = '0;
        else if (|acc_x[AW2-2:2*ACC_W])  pow_d = '1;
        else                             pow_d = acc_x[2*ACC_W-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (r_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready  = (state_q == ACCUM);
  assign r_valid  = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign r_power  = pow_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_goertzel_core.sv
// Bench for goertzel_core: block-level reference model plus directed and
// randomized stimulus; outputs compared against the model every cycle.
module tb_goertzel_core;
  localparam int AW = 20;
  localparam int PW = 2 * AW;
  localparam longint SMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (AW - 1));
  localparam longint PMAX = (longint'(1) << PW) - 1;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start = 1'b0;
  logic [17:0]        coef = '0;
  logic [15:0]        block_len = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [15:0] s_data = '0;
  logic               r_valid;
  logic               r_ready = 1'b1;
  logic [PW-1:0]      r_power;
  logic               busy;
  logic               overflow;

  int n_cmp = 0;
  int n_bad = 0;

  goertzel_core #(.ACC_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .coef(coef), .block_len(block_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_power(r_power),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit     m_acc, m_done, m_ovf;
  int     m_wait;
  int     m_len, m_cnt;
  longint m_coef, m_s1, m_s2, m_pow;

  function automatic longint bin_power(longint c, longint a, longint b);
    longint v;
    v = a * a + b * b - ((c * a) >>> 16) * b;
    if (v < 0) v = 0;
    if (v > PMAX) v = PMAX;
    return v;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_acc = 0; m_done = 0; m_ovf = 0; m_wait = 0; m_len = 0; m_cnt = 0;
      m_coef = 0; m_s1 = 0; m_s2 = 0; m_pow = 0;
    end else if (m_done) begin
      if (r_ready) m_done = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_done = 1;
        m_pow  = bin_power(m_coef, m_s1, m_s2);
      end
    end else if (m_acc) begin
      if (s_valid) begin
        longint t;
        t = longint'(s_data) + ((m_coef * m_s1) >>> 16) - m_s2;
        if (t > SMAX) begin t = SMAX; m_ovf = 1; end
        if (t < SMIN) begin t = SMIN; m_ovf = 1; end
        m_s2 = m_s1;
        m_s1 = t;
        m_cnt++;
        if (m_cnt == m_len) begin m_acc = 0; m_wait = 3; end
      end
    end else if (start && block_len != 0) begin
      m_coef = longint'($signed(coef));
      m_len  = int'(block_len);
      m_cnt  = 0; m_s1 = 0; m_s2 = 0; m_ovf = 0; m_acc = 1;
    end
  end

  // ---------------- every-cycle compare ----------------
  logic [PW+3:0] got_v, exp_v;
  always @(negedge clk) begin
    got_v = {s_ready, busy, r_valid, overflow, r_power};
    exp_v = {m_acc, (m_acc || m_wait > 0 || m_done), m_done, m_ovf, m_pow[PW-1:0]};
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      if (n_bad < 30)
        $display("FAIL outputs t=%0t rdy/busy/val/ovf/pow got %b %b %b %b %0d need %b %b %b %b %0d",
                 $time, s_ready, busy, r_valid, overflow, r_power,
                 exp_v[PW+3], exp_v[PW+2], exp_v[PW+1], exp_v[PW], exp_v[PW-1:0]);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d need %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [17:0] c, input logic [15:0] l);
    start = 1; coef = c; block_len = l;
    tick();
    start = 0;
  endtask

  task automatic send(input int x, input bit gap);
    int k;
    k = 0;
    s_valid = 1; s_data = 16'(x);
    while (s_ready !== 1'b1 && k < 50) begin tick(); k++; end
    if (k >= 50) chk("s_ready_wait", {63'd0, s_ready}, 64'd1);
    tick();
    s_valid = 0;
    if (gap) tick();
  endtask

  task automatic wait_res(input int max, output int n);
    n = 0;
    while (r_valid !== 1'b1 && n < max) begin tick(); n++; end
    if (r_valid !== 1'b1) chk("r_valid_wait", {63'd0, r_valid}, 64'd1);
  endtask

  task automatic basic(input bit gap, output int lat);
    do_start(18'd0, 16'd4);
    send(1, gap); send(0, gap); send(-1, gap); send(0, 1'b0);
    wait_res(20, lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rstn = 0;
    repeat (3) tick();
    rstn = 1;
    repeat (3) tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_valid", {63'd0, r_valid}, 64'd0);
    chk("rst_power", 64'(r_power), 64'd0);

    // Basic bin, back-to-back then gapped
    r_ready = 1;
    basic(1'b0, lat);
    chk("basic_lat", 64'(lat), 64'd3);
    chk("basic_pow", 64'(r_power), 64'd4);
    chk("model_basic", 64'(m_pow), 64'd4);
    tick();
    chk("pulse_low", {63'd0, r_valid}, 64'd0);
    basic(1'b1, lat);
    chk("gap_pow", 64'(r_power), 64'd4);
    tick();

    // Zero-length start ignored, then single sample with backpressure
    start = 1; block_len = 0; tick(); start = 0;
    chk("len0_busy", {63'd0, busy}, 64'd0);
    r_ready = 0;
    do_start(18'd0, 16'd1);
    send(100, 1'b0);
    wait_res(20, lat);
    chk("single_pow", 64'(r_power), 64'd10000);
    repeat (10) begin
      start = 1; block_len = 16'd5; s_valid = 1; s_data = 16'sd7;
      tick();
      chk("bp_valid", {63'd0, r_valid}, 64'd1);
    end
    start = 0; s_valid = 0; r_ready = 1;
    tick();
    chk("bp_idle", {63'd0, busy}, 64'd0);
    chk("bp_retain", 64'(r_power), 64'd10000);

    // Saturation
    do_start(18'h1FFFF, 16'd8);
    repeat (8) send(32767, 1'b0);
    wait_res(20, lat);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("model_sat", 64'(m_s1), 64'(SMAX));
    tick();
    do_start(18'd0, 16'd1);
    chk("ovf_clear", {63'd0, overflow}, 64'd0);
    send(5, 1'b0);
    wait_res(20, lat);
    tick();

    // Reset mid-block
    do_start(18'd0, 16'd4);
    send(1, 1'b0); send(0, 1'b0);
    rstn = 0; #1;
    chk("mid_busy", {63'd0, busy}, 64'd0);
    chk("mid_power", 64'(r_power), 64'd0);
    tick(); tick();
    chk("mid_valid", {63'd0, r_valid}, 64'd0);
    rstn = 1; tick();
    basic(1'b0, lat);
    chk("after_rst_pow", 64'(r_power), 64'd4);
    tick();

    // Randomized traffic: starts in any state, gappy valid, random backpressure
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      coef      = 18'($urandom);
      block_len = 16'($urandom_range(0, 12));
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
      r_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end
    start = 0; s_valid = 1; r_ready = 1;
    for (int i = 0; i < 100 && busy; i++) tick();
    s_valid = 0;
    chk("rand_drain", {63'd0, busy}, 64'd0);

    // Long block crossing the LEN_W sign bit
    do_start(18'd0, 16'h8001);
    s_valid = 1;
    for (int i = 0; i < 40000 && r_valid !== 1'b1; i++) begin
      s_data = 16'($urandom_range(0, 4) - 2);
      tick();
    end
    s_valid = 0;
    chk("long_valid", {63'd0, r_valid}, 64'd1);
    chk("long_pow", 64'(r_power), 64'(m_pow));
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/goertzel_core.md
Name: goertzel_core

Overview:
- Streaming single-bin Goertzel filter.
- Accepts a block of signed samples and runs the second-order recursion s[n] = x[n] + coef*s[n-1] - s[n-2].
- After the last sample of the block it computes the bin power s1^2 + s2^2 - coef*s1*s2.
- Sits directly upstream of the AXI-lite register block, which exposes the result, status and overflow flag to software.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- COEF_W, 18, coefficient width, signed Q2.16 (coef = 2cos(w)), range [-2.0, 2.0).
- ACC_W, 32, width of state registers s1/s2 (signed, saturating).
- LEN_W, 16, width of block_len.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse; begins a block when in IDLE.
- coef, input, COEF_W, Q2.16 coefficient; latched on accepted start.
- block_len, input, LEN_W, samples per block; latched on accepted start.
- s_valid, input, 1, sample valid.
- s_ready, output, 1, sample ready.
- s_data, input, DATA_W, signed sample.
- r_valid, output, 1, result valid.
- r_ready, input, 1, result accepted.
- r_power, output, 2*ACC_W, unsigned bin power.
- busy, output, 1, high in every state except IDLE.
- overflow, output, 1, sticky saturation flag for the current/last block.

Behaviour:
- Reset is asynchronous, active-low on rstn; clock is clk.
- Reset values: state=IDLE, s1=s2=0, count=0, s_ready=0, r_valid=0, r_power=0, busy=0, overflow=0.
- Reset mid-block aborts the block immediately. No partial result is produced.
- States: IDLE, ACCUM, SQ1, SQ2, CROSS, DONE.
- IDLE:
  - start=1 with block_len!=0: latch coef and block_len, clear s1, s2, count and overflow, go to ACCUM.
  - start with block_len==0 is ignored; state stays IDLE.
- ACCUM:
  - s_ready=1.
  - On each handshake (s_valid & s_ready):
    - p = (coef*s1) arithmetic-shifted right 16 (truncation toward -inf).
    - t = sext(s_data) + p - s2, computed at ACC_W+2 bits.
    - s2 <= s1; s1 <= sat(t) to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
    - overflow <= 1 if saturation occurred.
    - count++.
  - On the handshake where count reaches block_len: next state is SQ1, and s_ready drops the following cycle.
  - No bubbles: back-to-back samples are accepted one per cycle.
- SQ1: acc <= s1*s1 (signed 2*ACC_W+2 bits).
- SQ2: acc <= acc + s2*s2.
- CROSS:
  - acc <= acc - ((coef*s1)>>>16)*s2.
  - r_power <= clamp(acc_next, 0, 2^(2*ACC_W)-1).
- DONE:
  - r_valid=1; r_power held stable while r_valid=1 and r_ready=0.
  - On r_ready=1, r_valid drops and state returns to IDLE.
  - r_power retains its value after the handshake.
- Latency: r_valid is asserted 3 clock edges after the edge that accepts the last sample. With r_ready tied high, it is a single-cycle pulse.
- start is ignored in every state except IDLE, including start coincident with r_ready in DONE. A new block needs start in IDLE, at the earliest one cycle after the result handshake.
- s_valid outside ACCUM is ignored; s_ready=0 there.
- overflow stays set until the next accepted start or reset.
- block_len is unsigned; block_len=2^LEN_W-1 must complete correctly. count is LEN_W bits wide and never wraps before termination.

Test Plan:
- Reset/idle: assert rstn low for 3 cycles, release with no start. All outputs stay 0, s_ready=0, busy=0, r_valid never rises.
- Basic bin: coef=0, block_len=4, samples 1,0,-1,0 back-to-back. Expected s1=0, s2=-2; r_valid rises 3 edges after the 4th handshake with r_power=4. Repeat with s_valid toggled every other cycle: same result.
- Single sample: coef=0, block_len=1, sample 100. Expected r_power=10000. Also check start with block_len=0 is ignored (busy stays 0).
- Backpressure: hold r_ready=0 for 10 cycles in DONE. r_valid and r_power are stable; a start pulse and s_valid pulses during DONE have no effect. Raising r_ready returns to IDLE one cycle later.
- Overflow: ACC_W=20, coef=0x1FFFF, block_len=8, all samples 32767. overflow=1, s1 saturated at 2^19-1, result produced without hang. Next start clears overflow.
- Reset mid-block: rstn low after 2 of 4 samples. All outputs return to reset values, no r_valid. A subsequent normal block (Basic bin stimulus) gives r_power=4.
